regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 109 ++++++++++
 tb/tb_regfile_param.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Two-read/one-write register file with r0 hardwired to zero, a pending-producer scoreboard,
// and a sequential clear engine. Optional write-to-read forwarding under REGFILE_BYPASS_EN.
module regfile_param #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            sb_set,
  input  logic [AW-1:0]   sb_addr,
  output logic            pend1,
  output logic            pend2,
  input  logic            clr_req,
  output logic            clr_busy,
  output logic            dbg_state
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   counter;
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pending;
  logic            wr_acc;
  logic            clr_last;

  assign wr_acc    = we && (waddr != '0) && (state == IDLE);
  assign clr_last  = (counter == AW'(NREG - 1));
  assign dbg_state = (state == CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    clr_busy   = 1'b0;
    case (state)
      IDLE:    if (clr_req) state_next = CLEAR;
      CLEAR: begin
        clr_busy = 1'b1;
        if (clr_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter starts at 1 because r0 is never written; it holds at NREG-1 once the sweep ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
    end else if (state == IDLE) begin
      if (clr_req) counter <= AW'(1);
    end else if (!clr_last) begin
      counter <= counter + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[counter] <= '0;
    end else if (wr_acc) begin
      regs[waddr] <= wdata;
    end
  end

  // A same-edge sb_set is applied after the write clear so the new producer wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else if (state == IDLE) begin
      if (clr_req) begin
        pending <= '0;
      end else begin
        if (wr_acc) pending[waddr] <= 1'b0;
        if (sb_set && (sb_addr != '0)) pending[sb_addr] <= 1'b1;
      end
    end
  end

  always_comb begin
    rd1   = (ra1 == '0) ? '0 : regs[ra1];
    rd2   = (ra2 == '0) ? '0 : regs[ra2];
    pend1 = (ra1 != '0) && pending[ra1];
    pend2 = (ra2 != '0) && pending[ra2];
`ifdef REGFILE_BYPASS_EN
    if (wr_acc && (ra1 == waddr)) begin
      rd1   = wdata;
      pend1 = sb_set && (sb_addr == ra1);
    end
    if (wr_acc && (ra2 == waddr)) begin
      rd2   = wdata;
      pend2 = sb_set && (sb_addr == ra2);
    end
`endif
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed plus randomized bench for regfile_param against an array-based reference model.
module tb_regfile_param;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            we = 1'b0, sb_set = 1'b0, clr_req = 1'b0;
  logic [AW-1:0]   waddr = '0, ra1 = '0, ra2 = '0, sb_addr = '0;
  logic [XLEN-1:0] wdata = '0;
  logic [XLEN-1:0] rd1, rd2;
  logic            pend1, pend2, clr_busy, dbg_state;

  int passed = 0;
  int total  = 0;

  logic [XLEN-1:0] m_regs [NREG];
  bit              m_pend [NREG];
  int              m_clear_left = 0;

  regfile_param #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .sb_set(sb_set), .sb_addr(sb_addr), .pend1(pend1), .pend2(pend2),
    .clr_req(clr_req), .clr_busy(clr_busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_clear_left = 0;
  endtask

  function automatic bit write_now(logic [AW-1:0] a);
    return (m_clear_left == 0) && we && (waddr != '0) && (waddr == a);
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(logic [AW-1:0] a);
    if (rst || a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (write_now(a)) return wdata;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_pend(logic [AW-1:0] a);
    if (rst || a == '0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (write_now(a)) return sb_set && (sb_addr == a);
`endif
    return m_pend[a];
  endfunction

  task automatic chk(string tag, logic [XLEN-1:0] obs, logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_bit(string tag, logic obs, logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Compares every combinational output against the model for the inputs now applied.
  task automatic check_ports(string tag);
    #1;
    chk({tag, ".rd1"}, rd1, exp_rd(ra1));
    chk({tag, ".rd2"}, rd2, exp_rd(ra2));
    chk_bit({tag, ".pend1"}, pend1, exp_pend(ra1));
    chk_bit({tag, ".pend2"}, pend2, exp_pend(ra2));
    chk_bit({tag, ".clr_busy"}, clr_busy, !rst && (m_clear_left > 0));
    chk_bit({tag, ".dbg_state"}, dbg_state, !rst && (m_clear_left > 0));
  endtask

  // One rising edge; the model applies the architectural rules to the inputs held across it.
  task automatic tick();
    @(posedge clk);
    if (m_clear_left > 0) begin
      m_regs[NREG - m_clear_left] = '0;
      m_clear_left--;
    end else begin
      if (we && waddr != '0) begin
        m_regs[waddr] = wdata;
        m_pend[waddr] = 1'b0;
      end
      if (sb_set && sb_addr != '0) m_pend[sb_addr] = 1'b1;
      if (clr_req) begin
        for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
        m_clear_left = NREG - 1;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; sb_set = 1'b0; clr_req = 1'b0;
  endtask

  task automatic sweep(string tag);
    for (int i = 0; i < NREG; i++) begin
      ra1 = AW'(i);
      ra2 = AW'(NREG - 1 - i);
      check_ports(tag);
    end
  endtask

  task automatic fill_all();
    for (int i = 1; i < NREG; i++) begin
      we = 1'b1; waddr = AW'(i); wdata = $urandom() | 32'h1;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    int busy_cycles;
    model_reset();
    repeat (2) @(negedge clk);
    sweep("in_reset");
    rst = 1'b0;
    #2;
    sweep("after_reset");

    // Basic write then read, and writes to r0 are dropped.
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; tick();
    idle_inputs(); ra1 = 5'd5; ra2 = 5'd0; check_ports("r5_read");
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234; tick();
    idle_inputs(); ra1 = 5'd0; ra2 = 5'd5; check_ports("r0_zero");

    // Same-cycle read of a register being written: forwarded or old value.
    we = 1'b1; waddr = 5'd7; wdata = 32'h11112222; tick();
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; ra2 = 5'd7; ra1 = 5'd5;
    check_ports("r7_same_cycle");
    tick(); idle_inputs(); check_ports("r7_after");

    // Scoreboard: set, clear on write, and same-edge set wins.
    sb_set = 1'b1; sb_addr = 5'd3; tick();
    idle_inputs(); ra1 = 5'd3; ra2 = 5'd0; check_ports("sb_r3_set");
    we = 1'b1; waddr = 5'd3; wdata = 32'h33; check_ports("sb_r3_write_cycle");
    tick(); idle_inputs(); check_ports("sb_r3_cleared");
    we = 1'b1; waddr = 5'd3; wdata = 32'h44; sb_set = 1'b1; sb_addr = 5'd3;
    check_ports("sb_r3_both_cycle");
    tick(); idle_inputs(); check_ports("sb_r3_new_producer");

    // Randomized traffic, including occasional clear requests.
    for (int n = 0; n < 400; n++) begin
      we      = ($urandom_range(0, 3) != 0);
      waddr   = AW'($urandom_range(0, NREG - 1));
      wdata   = $urandom();
      sb_set  = ($urandom_range(0, 2) == 0);
      sb_addr = AW'($urandom_range(0, NREG - 1));
      ra1     = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, NREG - 1));
      ra2     = ($urandom_range(0, 3) == 0) ? sb_addr : AW'($urandom_range(0, NREG - 1));
      clr_req = ($urandom_range(0, 59) == 0);
      check_ports("rand");
      tick();
    end
    idle_inputs();
    while (m_clear_left > 0) tick();

    // Full clear with a dropped write to r9 and ignored sb_set during the sweep.
    fill_all();
    ra1 = 5'd9; ra2 = 5'd31;
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 2 * NREG && clr_busy; c++) begin
      busy_cycles++;
      we = 1'b1; waddr = 5'd9; wdata = 32'hBAD0BAD0;
      sb_set = 1'b1; sb_addr = 5'd9; clr_req = 1'b1;
      check_ports("clear_busy");
      tick();
    end
    idle_inputs();
    chk("clear_cycles", XLEN'(busy_cycles), XLEN'(NREG - 1));
    sweep("after_clear");

    // Reset in the middle of a clear sequence aborts it immediately.
    fill_all();
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    repeat (9) tick();
    #2 rst = 1'b1;
    model_reset();
    sweep("rst_mid_clear");
    @(negedge clk); rst = 1'b0; #1;
    sweep("after_abort");
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    ra1 = 5'd1; ra2 = 5'd2; check_ports("clear_reaccepted");
    for (int c = 0; c < 2 * NREG && m_clear_left > 0; c++) tick();
    check_ports("clear_done");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
